// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: NUM_MASTERS masters share one slave port.
// Optional bus watchdog built only when WB_ARB_TIMEOUT_EN is defined.
module wb_rr_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          wb_clk,
    input  logic                          wb_rst_n,
    input  logic [NUM_MASTERS*AW-1:0]     m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]     m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0]   m_sel_i,
    input  logic [NUM_MASTERS-1:0]        m_we_i,
    input  logic [NUM_MASTERS-1:0]        m_cyc_i,
    input  logic [NUM_MASTERS-1:0]        m_stb_i,
    input  logic [NUM_MASTERS*3-1:0]      m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]      m_bte_i,
    output logic [DW-1:0]                 m_dat_o,
    output logic [NUM_MASTERS-1:0]        m_ack_o,
    output logic [NUM_MASTERS-1:0]        m_err_o,
    output logic [AW-1:0]                 s_adr_o,
    output logic [DW-1:0]                 s_dat_o,
    output logic [DW/8-1:0]               s_sel_o,
    output logic                          s_we_o,
    output logic                          s_cyc_o,
    output logic                          s_stb_o,
    output logic [2:0]                    s_cti_o,
    output logic [1:0]                    s_bte_o,
    input  logic [DW-1:0]                 s_dat_i,
    input  logic                          s_ack_i,
    input  logic                          s_err_i,
    output logic [NUM_MASTERS-1:0]        grant_o
);

    localparam int SW = DW / 8;
    localparam int LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [NUM_MASTERS-1:0] w_grant_nxt;
    logic [LW-1:0]          r_owner;
    logic [LW-1:0]          w_owner_nxt;
    logic [LW-1:0]          r_last;
    logic [LW-1:0]          w_last_nxt;
    logic [LW-1:0]          w_winner;
    logic                   w_found;
    logic                   w_busy;
    logic                   w_own_cyc;
    logic                   w_timeout;

    assign w_busy    = (r_state == ST_BUSY);
    assign w_own_cyc = m_cyc_i[r_owner];

    // Round-robin scan starting just after the previous owner
    always_comb begin : p_rr
        int v_idx;
        w_found  = 1'b0;
        w_winner = '0;
        v_idx    = 0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            v_idx = (int'(r_last) + i) % NUM_MASTERS;
            if (!w_found && m_cyc_i[LW'(v_idx)]) begin
                w_found  = 1'b1;
                w_winner = LW'(v_idx);
            end
        end
    end

    // Owner-selected request path towards the slave
    always_comb begin
        s_adr_o = m_adr_i[r_owner*AW +: AW];
        s_dat_o = m_dat_i[r_owner*DW +: DW];
        s_sel_o = m_sel_i[r_owner*SW +: SW];
        s_we_o  = m_we_i[r_owner];
        s_cti_o = m_cti_i[r_owner*3 +: 3];
        s_bte_o = m_bte_i[r_owner*2 +: 2];
        s_cyc_o = w_busy && w_own_cyc && !w_timeout;
        s_stb_o = s_cyc_o && m_stb_i[r_owner];
    end

    // Slave responses reach the owner only; read data is broadcast
    always_comb begin
        m_dat_o = s_dat_i;
        m_ack_o = '0;
        m_err_o = '0;
        if (w_busy && !w_timeout && s_ack_i) begin
            m_ack_o = r_grant;
        end
        if (w_busy && (w_timeout || s_err_i)) begin
            m_err_o = r_grant;
        end
    end

    assign grant_o = r_grant;

    // Next-state: grant from idle, release when owner drops cyc
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        unique case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_BUSY;
                    w_owner_nxt = w_winner;
                    w_grant_nxt = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << w_winner;
                end
            end
            ST_BUSY: begin
                if (!w_own_cyc || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = r_owner;
                    w_grant_nxt = '0;
                end
            end
        endcase
    end

    // State register; master 0 wins the first tie after reset
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_last  <= LW'(NUM_MASTERS - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDW-1:0] r_wd;

    assign w_timeout = w_busy && (r_wd == WDW'(TIMEOUT_CYCLES));

    // Watchdog: counts unacknowledged strobe cycles, saturating
    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            r_wd <= '0;
        end else if ((!w_busy && w_found) || s_ack_i) begin
            r_wd <= '0;
        end else if (s_stb_o && (r_wd != WDW'(TIMEOUT_CYCLES))) begin
            r_wd <= r_wd + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

endmodule
